// File: rtl/pool_if_rx_if.sv
// Pool-output receive bus: data and flag val/rdy inbound streams plus the typed outbound burst port.
// slave = pool_if_rx side, master = pool output buffer and global-interface sink side.
interface pool_if_rx_if #(parameter int PORT_WIDTH = 128);
    logic                  IFPOOL_rdy;
    logic                  POOLIF_val;
    logic [PORT_WIDTH-1:0] POOLIF_data;
    logic                  IFPOOL_flg_rdy;
    logic                  POOLIF_flg_val;
    logic [PORT_WIDTH-1:0] POOLIF_flg_data;
    logic                  IFOUT_val;
    logic                  IFOUT_rdy;
    logic [PORT_WIDTH-1:0] IFOUT_data;
    logic                  IFOUT_type;
    logic                  IFOUT_last;
    logic                  IFOUT_pad;

    modport master (
        output POOLIF_val, POOLIF_data, POOLIF_flg_val, POOLIF_flg_data, IFOUT_rdy,
        input  IFPOOL_rdy, IFPOOL_flg_rdy, IFOUT_val, IFOUT_data, IFOUT_type, IFOUT_last, IFOUT_pad
    );
    modport slave (
        input  POOLIF_val, POOLIF_data, POOLIF_flg_val, POOLIF_flg_data, IFOUT_rdy,
        output IFPOOL_rdy, IFPOOL_flg_rdy, IFOUT_val, IFOUT_data, IFOUT_type, IFOUT_last, IFOUT_pad
    );
endinterface

// File: rtl/pool_if_rx.sv
// Pool-output receiver: data/flag FIFOs merged into typed BURST_LEN bursts, zero-padded on layer flush; POOL_IF_RX_STAT_EN adds word counters.
// Latency: first outbound word 2 cycles after inbound accept, then one word per cycle.
// Backpressure: outputs hold while IFOUT_rdy is low; inbound rdy drops with one FIFO entry of skid left.
module pool_if_rx_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [W-1:0]    wdat,
    input  logic            pop,
    output logic [W-1:0]    rdat,
    output logic [CNTW-1:0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt == CNTW'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst) !(pop && cnt == '0));
endmodule

module pool_if_rx #(
    parameter int PORT_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_LEN  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        layer_end,
    output logic        layer_done,
`ifdef POOL_IF_RX_STAT_EN
    output logic [15:0] stat_dat_cnt,
    output logic [15:0] stat_flg_cnt,
    output logic [15:0] stat_pad_cnt,
`endif
    pool_if_rx_if.slave bus
);
    localparam int CW   = $clog2(BURST_LEN);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_DAT, S_FLG, S_PAD, S_DONE} state_t;

    state_t                state;
    logic [CW-1:0]         word_cnt;
    logic                  rr;          // 0 = data burst next on a tie
    logic                  end_lat;
    logic                  out_vld, out_type, out_last, out_pad;
    logic [PORT_WIDTH-1:0] out_dat;
    logic [PORT_WIDTH-1:0] dat_head, flg_head, ld_dat;
    logic [CNTW-1:0]       dat_cnt, flg_cnt;
    logic                  dat_pop, flg_pop, ld, ld_type, ld_pad;
    logic                  dat_ne, flg_ne, load_ok, xfer, last_word;

    // Upstream commits a word one cycle after seeing rdy, so a presented word is always taken.
    pool_if_rx_fifo #(.W(PORT_WIDTH), .DEPTH(FIFO_DEPTH), .CNTW(CNTW)) u_dat_fifo (
        .clk(clk), .rst(rst), .push(bus.POOLIF_val), .wdat(bus.POOLIF_data),
        .pop(dat_pop), .rdat(dat_head), .cnt(dat_cnt)
    );
    pool_if_rx_fifo #(.W(PORT_WIDTH), .DEPTH(FIFO_DEPTH), .CNTW(CNTW)) u_flg_fifo (
        .clk(clk), .rst(rst), .push(bus.POOLIF_flg_val), .wdat(bus.POOLIF_flg_data),
        .pop(flg_pop), .rdat(flg_head), .cnt(flg_cnt)
    );

    assign bus.IFPOOL_rdy     = !rst && (dat_cnt <= CNTW'(FIFO_DEPTH - 2));
    assign bus.IFPOOL_flg_rdy = !rst && (flg_cnt <= CNTW'(FIFO_DEPTH - 2));
    assign bus.IFOUT_val      = out_vld;
    assign bus.IFOUT_data     = out_dat;
    assign bus.IFOUT_type     = out_type;
    assign bus.IFOUT_last     = out_last;
    assign bus.IFOUT_pad      = out_pad;

    assign dat_ne    = (dat_cnt != '0);
    assign flg_ne    = (flg_cnt != '0);
    assign xfer      = out_vld && bus.IFOUT_rdy;
    assign load_ok   = !out_vld || bus.IFOUT_rdy;
    assign last_word = (word_cnt == CW'(BURST_LEN - 1));

    always_comb begin
        dat_pop = 1'b0;
        flg_pop = 1'b0;
        if (load_ok) begin
            case (state)
                S_IDLE: begin
                    dat_pop = dat_ne && (!flg_ne || !rr);
                    flg_pop = flg_ne && (!dat_ne || rr);
                end
                S_DAT:   dat_pop = dat_ne;
                S_FLG:   flg_pop = flg_ne;
                default: ;
            endcase
        end
        ld      = dat_pop || flg_pop || (state == S_PAD && load_ok);
        ld_pad  = (state == S_PAD);
        ld_type = flg_pop || (ld_pad && out_type);
        ld_dat  = dat_pop ? dat_head : (flg_pop ? flg_head : '0);
    end

    // word_cnt counts words loaded into the output register within the current burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            rr         <= 1'b0;
            end_lat    <= 1'b0;
            layer_done <= 1'b0;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_type   <= 1'b0;
            out_last   <= 1'b0;
            out_pad    <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if (layer_end)             end_lat <= 1'b1;
            else if (state == S_DONE)  end_lat <= 1'b0;

            if (ld) begin
                out_vld  <= 1'b1;
                out_dat  <= ld_dat;
                out_type <= ld_type;
                out_pad  <= ld_pad;
                out_last <= last_word;
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                if (last_word) rr <= ~rr;
            end else if (xfer) begin
                out_vld <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (dat_pop)      state <= last_word ? S_IDLE : S_DAT;
                    else if (flg_pop) state <= last_word ? S_IDLE : S_FLG;
                    else if (end_lat && !dat_ne && !flg_ne && load_ok) begin
                        state      <= S_DONE;
                        layer_done <= 1'b1;
                    end
                end
                S_DAT: begin
                    if (ld && last_word)         state <= S_IDLE;
                    else if (!dat_ne && end_lat) state <= S_PAD;
                end
                S_FLG: begin
                    if (ld && last_word)         state <= S_IDLE;
                    else if (!flg_ne && end_lat) state <= S_PAD;
                end
                S_PAD:   if (ld && last_word) state <= S_IDLE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef POOL_IF_RX_STAT_EN
    always_ff @(posedge clk) begin
        if (rst || layer_done) begin
            stat_dat_cnt <= '0;
            stat_flg_cnt <= '0;
            stat_pad_cnt <= '0;
        end else if (xfer) begin
            if (out_pad) begin
                if (stat_pad_cnt != 16'hFFFF) stat_pad_cnt <= stat_pad_cnt + 16'd1;
            end else if (out_type) begin
                if (stat_flg_cnt != 16'hFFFF) stat_flg_cnt <= stat_flg_cnt + 16'd1;
            end else begin
                if (stat_dat_cnt != 16'hFFFF) stat_dat_cnt <= stat_dat_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_pool_if_rx.sv
// Bench for pool_if_rx: upstream model with one-cycle read latency, random/stalled sink, per-stream scoreboard.
module tb_pool_if_rx;
    localparam int W  = 128;
    localparam int BL = 64;
    typedef logic [W-1:0] word_t;

    logic clk = 1'b0;
    logic rst, layer_end, layer_done;
`ifdef POOL_IF_RX_STAT_EN
    logic [15:0] s_dat, s_flg, s_pad;
`endif
    always #5 clk = ~clk;

    pool_if_rx_if #(.PORT_WIDTH(W)) bus();

    pool_if_rx #(.PORT_WIDTH(W), .FIFO_DEPTH(4), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .layer_end(layer_end), .layer_done(layer_done),
`ifdef POOL_IF_RX_STAT_EN
        .stat_dat_cnt(s_dat), .stat_flg_cnt(s_flg), .stat_pad_cnt(s_pad),
`endif
        .bus(bus)
    );

    typedef struct {
        int n_dat; int n_flg; bit do_end; bit throttle;
        int e_db; int e_fb; int e_pad; int e_done; bit e_first;
    } vec_t;
    vec_t tbl[8];

    word_t dat_src[$], flg_src[$], exp_dat[$], exp_flg[$];
    bit    dat_req, flg_req;
    int    sink_mode;   // 0 always ready, 1 random, 2 stalled
    int    cyc = 0;
    int    nvec = 0, nerr = 0;
    int    bcnt, dbursts, fbursts, pad_cnt, done_cnt;
    bit    btype, first_seen, first_type, val_seen, push_seen, prev_stall;
    int    first_val_cyc, first_push_cyc, last_xfer_cyc, done_cyc;
    logic [131:0] prev_out, cur_out;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic word_t rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_bench();
        dat_src.delete(); flg_src.delete(); exp_dat.delete(); exp_flg.delete();
        dat_req = 0; flg_req = 0; layer_end = 0;
        bcnt = 0; dbursts = 0; fbursts = 0; pad_cnt = 0; done_cnt = 0;
        first_seen = 0; val_seen = 0; push_seen = 0; prev_stall = 0;
        first_val_cyc = 0; first_push_cyc = 0; last_xfer_cyc = 0; done_cyc = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; clear_bench();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic load_words(input int nd, input int nf);
        for (int k = 0; k < nd; k++) dat_src.push_back(rand_word());
        for (int k = 0; k < nf; k++) flg_src.push_back(rand_word());
    endtask

    task automatic run_quiet(input bit do_end, output bit ok);
        bit sent;
        bit drained;
        sent = 0; ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            layer_end = 0;
            drained = (dat_src.size() == 0) && (flg_src.size() == 0) && !dat_req && !flg_req;
            if (do_end && drained && !sent) begin
                layer_end = 1; sent = 1;
            end else if (drained && exp_dat.size() == 0 && exp_flg.size() == 0 && bcnt == 0 &&
                         !bus.IFOUT_val && (!do_end || done_cnt > 0)) begin
                ok = 1;
                break;
            end
        end
        layer_end = 0;
    endtask

    task automatic check_rst_outs(input string tag);
        check({tag, "_ctl"}, {bus.IFOUT_val, bus.IFOUT_type, bus.IFOUT_last, bus.IFOUT_pad,
                             layer_done, bus.IFPOOL_rdy, bus.IFPOOL_flg_rdy}, 0);
        check({tag, "_data"}, bus.IFOUT_data, 0);
    endtask

    // Upstream: rdy seen this cycle -> word presented next cycle. Also drives sink ready.
    initial begin
        word_t w;
        bus.POOLIF_val = 0; bus.POOLIF_data = '0;
        bus.POOLIF_flg_val = 0; bus.POOLIF_flg_data = '0;
        bus.IFOUT_rdy = 0;
        forever begin
            @(posedge clk); #2;
            if (dat_req) begin
                w = dat_src.pop_front();
                bus.POOLIF_val = 1; bus.POOLIF_data = w; exp_dat.push_back(w);
            end else bus.POOLIF_val = 0;
            if (flg_req) begin
                w = flg_src.pop_front();
                bus.POOLIF_flg_val = 1; bus.POOLIF_flg_data = w; exp_flg.push_back(w);
            end else bus.POOLIF_flg_val = 0;
            if ((dat_req || flg_req) && !push_seen) begin
                push_seen = 1; first_push_cyc = cyc;
            end
            dat_req = bus.IFPOOL_rdy && (dat_src.size() > 0);
            flg_req = bus.IFPOOL_flg_rdy && (flg_src.size() > 0);
            case (sink_mode)
                0:       bus.IFOUT_rdy = 1;
                1:       bus.IFOUT_rdy = 1'($urandom_range(0, 1));
                default: bus.IFOUT_rdy = 0;
            endcase
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Outbound monitor and scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) prev_stall = 0;
        else begin
            cur_out = {bus.IFOUT_val, bus.IFOUT_type, bus.IFOUT_last, bus.IFOUT_pad, bus.IFOUT_data};
            if (prev_stall) check("hold", cur_out, prev_out);
            prev_stall = bus.IFOUT_val && !bus.IFOUT_rdy;
            prev_out   = cur_out;
            if (bus.IFOUT_val && !val_seen) begin
                val_seen = 1; first_val_cyc = cyc;
            end
            if (layer_done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (bus.IFOUT_val && bus.IFOUT_rdy) begin
                if (bcnt == 0) begin
                    btype = bus.IFOUT_type;
                    if (btype) fbursts++; else dbursts++;
                    if (!first_seen) begin first_seen = 1; first_type = btype; end
                end else check("type_const", bus.IFOUT_type, btype);
                check("last", bus.IFOUT_last, bcnt == BL - 1);
                if (bus.IFOUT_pad) begin
                    pad_cnt++;
                    check("pad_data", bus.IFOUT_data, 0);
                end else if (!bus.IFOUT_type) begin
                    if (exp_dat.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL dat_extra: got %0h with no data word outstanding", bus.IFOUT_data);
                    end else check("dat", bus.IFOUT_data, exp_dat.pop_front());
                end else begin
                    if (exp_flg.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL flg_extra: got %0h with no flag word outstanding", bus.IFOUT_data);
                    end else check("flg", bus.IFOUT_data, exp_flg.pop_front());
                end
                bcnt = (bcnt == BL - 1) ? 0 : bcnt + 1;
                last_xfer_cyc = cyc;
            end
        end
    end

    initial begin
        bit ok;
        tbl[0] = '{64,  0,  0, 0, 1, 0, 0,  0, 0};
        tbl[1] = '{64,  64, 0, 0, 1, 1, 0,  0, 0};
        tbl[2] = '{10,  0,  1, 0, 1, 0, 54, 1, 0};
        tbl[3] = '{0,   0,  1, 0, 0, 0, 0,  1, 0};
        tbl[4] = '{64,  64, 0, 1, 1, 1, 0,  0, 0};
        tbl[5] = '{70,  64, 1, 0, 2, 1, 58, 1, 0};
        tbl[6] = '{0,   5,  1, 0, 0, 1, 59, 1, 1};
        tbl[7] = '{128, 0,  0, 1, 2, 0, 0,  0, 0};

        rst = 1; sink_mode = 0;
        clear_bench();
        repeat (2) @(posedge clk);
        #1 check_rst_outs("reset");
        rst = 0;
        @(posedge clk); #1;
        check("rdy_after_rst", {bus.IFPOOL_rdy, bus.IFPOOL_flg_rdy}, 2'b11);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            sink_mode = tbl[i].throttle ? 1 : 0;
            load_words(tbl[i].n_dat, tbl[i].n_flg);
            run_quiet(tbl[i].do_end, ok);
            check($sformatf("v%0d_quiet", i), ok, 1);
            check($sformatf("v%0d_dbursts", i), dbursts, tbl[i].e_db);
            check($sformatf("v%0d_fbursts", i), fbursts, tbl[i].e_fb);
            check($sformatf("v%0d_pads", i), pad_cnt, tbl[i].e_pad);
            check($sformatf("v%0d_done", i), done_cnt, tbl[i].e_done);
            if (tbl[i].n_dat + tbl[i].n_flg > 0) begin
                check($sformatf("v%0d_first_type", i), first_type, tbl[i].e_first);
                check($sformatf("v%0d_first_lat", i), first_val_cyc - first_push_cyc, 2);
                if (tbl[i].do_end)
                    check($sformatf("v%0d_done_lat", i), done_cyc - last_xfer_cyc, 1);
            end
        end

        // Sink stall mid-burst: outputs hold, FIFO fills, inbound rdy drops, nothing lost.
        do_reset();
        sink_mode = 0;
        load_words(64, 0);
        for (int k = 0; k < 400 && bcnt < 10; k++) @(posedge clk);
        #1 sink_mode = 2;
        repeat (20) @(posedge clk);
        #1 check("stall_rdy_low", bus.IFPOOL_rdy, 0);
        check("stall_val_held", bus.IFOUT_val, 1);
        sink_mode = 0;
        run_quiet(0, ok);
        check("stall_quiet", ok, 1);
        check("stall_dbursts", dbursts, 1);
        check("stall_pads", pad_cnt, 0);

        // layer_end in IDLE with nothing pending: layer_done two cycles later, no output.
        do_reset();
        @(posedge clk); #1 layer_end = 1;
        @(posedge clk); #1 layer_end = 0;
        check("empty_done_c1", {layer_done, bus.IFOUT_val}, 2'b00);
        @(posedge clk); #1;
        check("empty_done_c2", {layer_done, bus.IFOUT_val}, 2'b10);
        @(posedge clk); #1;
        check("empty_done_c3", {layer_done, bus.IFOUT_val}, 2'b00);

        // Reset mid-burst abandons it; the next stream starts a fresh burst.
        do_reset();
        load_words(64, 0);
        for (int k = 0; k < 400 && bcnt < 30; k++) @(posedge clk);
        check("midrst_reach", bcnt >= 30, 1);
        @(posedge clk); #1;
        rst = 1; clear_bench();
        @(posedge clk); #1;
        check_rst_outs("midrst");
        rst = 0;
        @(negedge clk);
        check("midrst_rdy", {bus.IFPOOL_rdy, bus.IFPOOL_flg_rdy}, 2'b11);
        load_words(64, 0);
        run_quiet(0, ok);
        check("midrst_quiet", ok, 1);
        check("midrst_dbursts", dbursts, 1);
        check("midrst_pads", pad_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
